// File: rtl/seg7_scan_driver.sv
// Multiplexed 5-digit common-anode 7-segment scan driver.
// Features: per-frame input snapshot, inter-digit blanking, optional leading-zero suppression.
module seg7_scan_driver #(
  parameter int unsigned DIV          = 2000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter bit          LZ_SUPPRESS  = 1'b1
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] d5_in,
  input  logic [3:0] d4_in,
  input  logic [3:0] d3_in,
  input  logic [3:0] d2_in,
  input  logic [3:0] d1_in,
  output logic [6:0] seg_n,
  output logic [4:0] an_n,
  output logic       frame_start
);

  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DIG_W  = 3;
  localparam int unsigned NDIG   = 5;
  localparam logic [DIG_W-1:0] DIG_D5 = DIG_W'(NDIG - 1);
  localparam logic [DIG_W-1:0] DIG_D1 = DIG_W'(0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [6:0] SEG_DARK = 7'h7F;
  localparam logic [4:0] AN_DARK  = 5'h1F;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  // Snapshot storage: index 4 holds D5 (leftmost), index 0 holds D1.
  typedef logic [NDIG-1:0][3:0] digits_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIG_W-1:0]   digit_q, digit_d;
  digits_t            snap_q, snap_d;
  logic [6:0]         seg_d;
  logic [4:0]         an_d;
  logic               frame_d;
  logic               zero_run;
  logic               lz_blank;
  digits_t            live_digits;

  assign live_digits = {d5_in, d4_in, d3_in, d2_in, d1_in};

  // BCD to active-low gfedcba; invalid codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      digit_q     <= DIG_D5;
      snap_q      <= '0;
      seg_n       <= SEG_DARK;
      an_n        <= AN_DARK;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      snap_q      <= snap_d;
      seg_n       <= seg_d;
      an_n        <= an_d;
      frame_start <= frame_d;
    end
  end

  // Next state plus outputs derived from the next cnt/digit/snapshot so they align with cnt.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    digit_d  = digit_q;
    snap_d   = snap_q;
    frame_d  = 1'b0;
    seg_d    = SEG_DARK;
    an_d     = AN_DARK;
    zero_run = 1'b1;
    lz_blank = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        digit_d = DIG_D5;
        if (en) begin
          state_d = SCAN;
          snap_d  = live_digits;
          frame_d = 1'b1;
        end
      end
      SCAN: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          digit_d = DIG_D5;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (digit_q == DIG_D1) begin
            digit_d = DIG_D5;
            snap_d  = live_digits;
            frame_d = 1'b1;
          end else begin
            digit_d = digit_q - DIG_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        digit_d = DIG_D5;
      end
    endcase

    // A digit is a leading zero if it and every higher snapshot digit are zero.
    for (int i = NDIG - 1; i >= 1; i--) begin
      if ((DIG_W'(i) >= digit_d) && (snap_d[DIG_W'(i)] != 4'd0)) begin
        zero_run = 1'b0;
      end
    end
    lz_blank = LZ_SUPPRESS && (digit_d != DIG_D1) && zero_run;

    if ((state_d == SCAN) && (cnt_d >= CNT_BLANK) && !lz_blank) begin
      an_d  = ~(5'b00001 << digit_d);
      seg_d = decode(snap_d[digit_d]);
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: table vectors, corner sequences, random run vs model.
module tb_seg7_scan_driver;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 5 * DIV;

  logic       sysclk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] d5, d4, d3, d2, d1;
  logic [6:0] seg0, seg1;
  logic [4:0] an0, an1;
  logic       fs0, fs1;

  int checks   = 0;
  int failures = 0;

  // Reference model state: frame-relative cycle counter and snapshot (index 4 = D5).
  bit         m_active;
  int         m_t;
  logic [3:0] m_snap [5];
  bit         m_fs;
  logic [6:0] dec_tab [16];

  typedef struct {
    logic [4:0][3:0] d;
    bit              lz;
    logic [4:0][6:0] seg;
    logic [4:0][4:0] an;
  } vec_t;
  vec_t vecs [5];

  always #5 sysclk = ~sysclk;

  seg7_scan_driver #(.DIV(DIV), .BLANK_CYCLES(BLANK), .LZ_SUPPRESS(1'b0)) dut0 (
    .sysclk(sysclk), .rst(rst), .en(en),
    .d5_in(d5), .d4_in(d4), .d3_in(d3), .d2_in(d2), .d1_in(d1),
    .seg_n(seg0), .an_n(an0), .frame_start(fs0)
  );

  seg7_scan_driver #(.DIV(DIV), .BLANK_CYCLES(BLANK), .LZ_SUPPRESS(1'b1)) dut1 (
    .sysclk(sysclk), .rst(rst), .en(en),
    .d5_in(d5), .d4_in(d4), .d3_in(d3), .d2_in(d2), .d1_in(d1),
    .seg_n(seg1), .an_n(an1), .frame_start(fs1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, act, exp, m_t, $time);
    end
  endtask

  task automatic set_digits(input logic [4:0][3:0] v);
    d5 = v[4]; d4 = v[3]; d3 = v[2]; d2 = v[1]; d1 = v[0];
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_t      = 0;
    m_fs     = 1'b0;
    for (int i = 0; i < 5; i++) m_snap[i] = 4'd0;
  endtask

  task automatic model_take_snapshot();
    m_snap[4] = d5; m_snap[3] = d4; m_snap[2] = d3; m_snap[1] = d2; m_snap[0] = d1;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_update();
    m_fs = 1'b0;
    if (!m_active && en) begin
      m_active = 1'b1;
      m_t      = 0;
      model_take_snapshot();
      m_fs     = 1'b1;
    end else if (m_active && !en) begin
      m_active = 1'b0;
      m_t      = 0;
    end else if (m_active) begin
      m_t = m_t + 1;
      if (m_t == FRAME) begin
        m_t = 0;
        model_take_snapshot();
        m_fs = 1'b1;
      end
    end
  endtask

  // Expected display from slot = t/DIV, position = t%DIV and the snapshot.
  task automatic model_expect(input bit lz, output logic [6:0] es, output logic [4:0] ea);
    int  k;
    bit  blank;
    es = 7'h7F;
    ea = 5'h1F;
    if (m_active && ((m_t % DIV) >= BLANK)) begin
      k = 4 - (m_t / DIV);
      blank = 1'b0;
      if (lz && (k != 0)) begin
        blank = 1'b1;
        for (int j = k; j <= 4; j++) if (m_snap[j] != 4'd0) blank = 1'b0;
      end
      if (!blank) begin
        es = dec_tab[m_snap[k]];
        ea = 5'h1F & ~(5'(1) << k);
      end
    end
  endtask

  // One clock edge; sample 1 time unit later and compare both instances against the model.
  task automatic step();
    logic [6:0] es;
    logic [4:0] ea;
    @(posedge sysclk);
    #1;
    model_update();
    model_expect(1'b0, es, ea);
    check("seg_lz0", 32'(seg0), 32'(es));
    check("an_lz0",  32'(an0),  32'(ea));
    check("fs_lz0",  32'(fs0),  32'(m_fs));
    model_expect(1'b1, es, ea);
    check("seg_lz1", 32'(seg1), 32'(es));
    check("an_lz1",  32'(an1),  32'(ea));
    check("fs_lz1",  32'(fs1),  32'(m_fs));
  endtask

  // Hold reset across one edge with the given en, check dark outputs, then release.
  task automatic do_reset(input logic en_v);
    en  = en_v;
    rst = 1'b1;
    model_reset();
    @(posedge sysclk);
    #1;
    check("rst_seg0", 32'(seg0), 32'h7F);
    check("rst_an0",  32'(an0),  32'h1F);
    check("rst_fs0",  32'(fs0),  32'h0);
    check("rst_seg1", 32'(seg1), 32'h7F);
    check("rst_an1",  32'(an1),  32'h1F);
    check("rst_fs1",  32'(fs1),  32'h0);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] vs;
    logic [4:0] va;
    int         k;

    rst = 1'b1;
    en  = 1'b0;
    d5 = 4'd0; d4 = 4'd0; d3 = 4'd0; d2 = 4'd0; d1 = 4'd0;

    dec_tab[0] = 7'h40; dec_tab[1] = 7'h79; dec_tab[2] = 7'h24; dec_tab[3] = 7'h30;
    dec_tab[4] = 7'h19; dec_tab[5] = 7'h12; dec_tab[6] = 7'h02; dec_tab[7] = 7'h78;
    dec_tab[8] = 7'h00; dec_tab[9] = 7'h10;
    for (int i = 10; i < 16; i++) dec_tab[i] = 7'h3F;

    vecs[0] = '{d: {4'd1, 4'd2, 4'd3, 4'd4, 4'd5}, lz: 1'b0,
                seg: {7'h79, 7'h24, 7'h30, 7'h19, 7'h12},
                an:  {5'h0F, 5'h17, 5'h1B, 5'h1D, 5'h1E}};
    vecs[1] = '{d: {4'd0, 4'd0, 4'd7, 4'd0, 4'd0}, lz: 1'b1,
                seg: {7'h7F, 7'h7F, 7'h78, 7'h40, 7'h40},
                an:  {5'h1F, 5'h1F, 5'h1B, 5'h1D, 5'h1E}};
    vecs[2] = '{d: {4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, lz: 1'b1,
                seg: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40},
                an:  {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1E}};
    vecs[3] = '{d: {4'hC, 4'd0, 4'd0, 4'd0, 4'd0}, lz: 1'b1,
                seg: {7'h3F, 7'h40, 7'h40, 7'h40, 7'h40},
                an:  {5'h0F, 5'h17, 5'h1B, 5'h1D, 5'h1E}};
    vecs[4] = '{d: {4'd0, 4'd0, 4'd0, 4'd0, 4'd9}, lz: 1'b0,
                seg: {7'h40, 7'h40, 7'h40, 7'h40, 7'h10},
                an:  {5'h0F, 5'h17, 5'h1B, 5'h1D, 5'h1E}};

    // Reset with en high, then frame_start on the first edge after release.
    set_digits({4'd1, 4'd2, 4'd3, 4'd4, 4'd5});
    do_reset(1'b1);
    step();
    check("t1_first_fs", 32'(fs0), 32'h1);

    // Table vectors: one full frame each, checked at slot start, drive start and slot end.
    for (int v = 0; v < 5; v++) begin
      set_digits(vecs[v].d);
      do_reset(1'b0);
      en = 1'b1;
      step();
      check("tab_fs", 32'(vecs[v].lz ? fs1 : fs0), 32'h1);
      for (int t = 0; t < FRAME + 1; t++) begin
        if (t > 0) step();
        k  = 4 - ((t % FRAME) / DIV);
        vs = vecs[v].lz ? seg1 : seg0;
        va = vecs[v].lz ? an1 : an0;
        if ((t % DIV) == 0) begin
          check("tab_blank_an",  32'(va), 32'h1F);
          check("tab_blank_seg", 32'(vs), 32'h7F);
        end else if ((t % DIV) == BLANK || (t % DIV) == DIV - 1) begin
          check("tab_seg", 32'(vs), 32'(vecs[v].seg[k]));
          check("tab_an",  32'(va), 32'(vecs[v].an[k]));
        end
      end
      check("tab_wrap_fs", 32'(fs0), 32'h1);
    end

    // Mid-frame input change stays hidden until the next snapshot.
    set_digits({4'd0, 4'd0, 4'd0, 4'd0, 4'd3});
    do_reset(1'b0);
    en = 1'b1;
    step();
    for (int t = 1; t < 2 * FRAME; t++) begin
      step();
      if (t == DIV + 2) d1 = 4'd9;
      if (t == 4 * DIV + 2)         check("hold_old_d1", 32'(seg0), 32'h30);
      if (t == FRAME + 4 * DIV + 2) check("show_new_d1", 32'(seg0), 32'h10);
    end

    // Dropping en during a drive phase goes dark next edge; raising it restarts at D5.
    set_digits({4'd1, 4'd2, 4'd3, 4'd4, 4'd5});
    do_reset(1'b0);
    en = 1'b1;
    step();
    for (int t = 1; t <= 2 * DIV + 2; t++) step();
    check("d3_driving", 32'(an0), 32'h1B);
    en = 1'b0;
    step();
    check("en_drop_an",  32'(an0), 32'h1F);
    check("en_drop_seg", 32'(seg0), 32'h7F);
    step();
    check("idle_fs", 32'(fs0), 32'h0);
    en = 1'b1;
    step();
    check("restart_fs", 32'(fs0), 32'h1);
    check("restart_an", 32'(an0), 32'h1F);
    step();
    step();
    check("restart_d5_an",  32'(an0),  32'h0F);
    check("restart_d5_seg", 32'(seg0), 32'h79);

    // Randomized run against the model, biased toward zeros to exercise suppression.
    do_reset(1'b0);
    for (int n = 0; n < 4000; n++) begin
      en = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 19) == 0) d5 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) d4 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) d3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) d2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) d1 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
